// File: rtl/fractal_sync_pkg.sv
// Shared response types and constants for the fractal sync transmit path.
// The in/out response pairs differ only in dst width: each TX stage strips NUM_CH low dst bits.
package fractal_sync_pkg;

    localparam int unsigned DROP_CNT_W = 8;
    localparam int unsigned IN_DST_W   = 8;

    typedef struct packed {
        logic                wake;
        logic [IN_DST_W-1:0] dst;
        logic                error;
    } fsync_rsp_in_t;

    // Output of a 2-channel stage
    typedef struct packed {
        logic                  wake;
        logic [IN_DST_W-3:0]   dst;
        logic                  error;
    } fsync_rsp_out_t;

    // Output of a 4-channel stage
    typedef struct packed {
        logic                  wake;
        logic [IN_DST_W-5:0]   dst;
        logic                  error;
    } fsync_rsp_out_4ch_t;

endpackage

// File: rtl/fractal_sync_tx_ch_fifo.sv
// Per-channel fall-through FIFO: push into empty shows on the output in the same cycle,
// a push into a full FIFO is accepted when it pops that cycle, otherwise it is dropped and counted.
module fractal_sync_tx_ch_fifo
    import fractal_sync_pkg::*;
#(
    parameter int unsigned DEPTH  = 2,
    parameter type         data_t = logic,
    localparam int unsigned UW    = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  data_t                 data_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output data_t                 data_o,
    output logic [UW-1:0]         usage_o,
    input  logic                  clr_error_i,
    output logic                  error_overflow_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    data_t                 mem_q [DEPTH];
    data_t                 mem_d [DEPTH];
    logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [UW-1:0]         usage_q, usage_d;
    logic                  err_q, err_d;
    logic [DROP_CNT_W-1:0] cnt_q, cnt_d;
    logic                  empty, full, pop, pop_mem, write, overflow;

    // Pointers wrap at DEPTH explicitly so non-power-of-two depths work
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        empty    = (usage_q == '0);
        full     = (usage_q == UW'(DEPTH));
        valid_o  = !empty || push_i;
        data_o   = !empty ? mem_q[rptr_q] : (push_i ? data_i : '0);
        pop      = valid_o && ready_i;
        pop_mem  = pop && !empty;
        // A push straight through an empty FIFO that pops at once is never stored
        write    = push_i && (!full || pop) && !(empty && pop);
        overflow = push_i && full && !pop;

        mem_d = mem_q;
        if (write) begin
            mem_d[wptr_q] = data_i;
        end
        wptr_d = write   ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop_mem ? ptr_inc(rptr_q) : rptr_q;

        case ({write, pop_mem})
            2'b10:   usage_d = usage_q + 1'b1;
            2'b01:   usage_d = usage_q - 1'b1;
            default: usage_d = usage_q;
        endcase

        // Overflow wins over a coincident clear: flag stays set, count restarts at one
        if (overflow) begin
            err_d = 1'b1;
            cnt_d = clr_error_i ? DROP_CNT_W'(1) : ((cnt_q == '1) ? cnt_q : cnt_q + 1'b1);
        end else if (clr_error_i) begin
            err_d = 1'b0;
            cnt_d = '0;
        end else begin
            err_d = err_q;
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            usage_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            usage_q <= usage_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign usage_o          = usage_q;
    assign error_overflow_o = err_q;
    assign drop_cnt_o       = cnt_q;

endmodule

// File: rtl/fractal_sync_tx_nch.sv
// Fans a sync response out to NUM_CH channel FIFOs by dst[NUM_CH-1:0] (multicast), stripping those bits.
// Latency 0 (COMB_IN=1) or 1 cycle (COMB_IN=0) to valid_o; per-channel valid/ready, full channels drop and count.
module fractal_sync_tx_nch #(
    parameter type         fsync_rsp_in_t  = fractal_sync_pkg::fsync_rsp_in_t,
    parameter type         fsync_rsp_out_t = fractal_sync_pkg::fsync_rsp_out_t,
    parameter int unsigned NUM_CH          = 2,
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter bit          COMB_IN         = 1'b0
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  fsync_rsp_in_t                           rsp_i,
    output logic                                    valid_o          [NUM_CH],
    output fsync_rsp_out_t                          rsp_o            [NUM_CH],
    input  logic                                    ready_i          [NUM_CH],
    output logic [$clog2(FIFO_DEPTH+1)-1:0]         usage_o          [NUM_CH],
    output logic                                    error_overflow_o [NUM_CH],
    output logic [fractal_sync_pkg::DROP_CNT_W-1:0] drop_cnt_o       [NUM_CH],
    input  logic                                    clr_error_i      [NUM_CH]
);

    // wake and error are single bits; the rest of each struct is dst
    localparam int unsigned IN_DW  = $bits(fsync_rsp_in_t) - 2;
    localparam int unsigned OUT_DW = $bits(fsync_rsp_out_t) - 2;

    if (NUM_CH < 2 || (NUM_CH & (NUM_CH - 1)) != 0) begin : g_bad_num_ch
        $error("NUM_CH must be a power of two and >= 2");
    end
    if (FIFO_DEPTH < 1) begin : g_bad_depth
        $error("FIFO_DEPTH must be >= 1");
    end
    if (OUT_DW != IN_DW - NUM_CH) begin : g_bad_dst_w
        $error("output dst width must equal input dst width minus NUM_CH");
    end

    logic [NUM_CH-1:0] in_mask;
    logic [NUM_CH-1:0] push_mask;
    fsync_rsp_in_t     push_rsp;
    fsync_rsp_out_t    push_out;

    assign in_mask = rsp_i.wake ? rsp_i.dst[NUM_CH-1:0] : '0;

    if (COMB_IN) begin : g_comb_in
        assign push_mask = rst_ni ? in_mask : '0;
        assign push_rsp  = rsp_i;
    end else begin : g_reg_in
        fsync_rsp_in_t     rsp_q, rsp_d;
        logic [NUM_CH-1:0] mask_q, mask_d;

        always_comb begin
            rsp_d  = rsp_i.wake ? rsp_i : rsp_q;
            mask_d = in_mask;
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rsp_q  <= '0;
                mask_q <= '0;
            end else begin
                rsp_q  <= rsp_d;
                mask_q <= mask_d;
            end
        end

        assign push_mask = mask_q;
        assign push_rsp  = rsp_q;
    end

    always_comb begin
        push_out       = '0;
        push_out.wake  = push_rsp.wake;
        push_out.dst   = OUT_DW'(push_rsp.dst >> NUM_CH);
        push_out.error = push_rsp.error;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        fractal_sync_tx_ch_fifo #(
            .DEPTH  (FIFO_DEPTH),
            .data_t (fsync_rsp_out_t)
        ) u_fifo (
            .clk_i            (clk_i),
            .rst_ni           (rst_ni),
            .push_i           (push_mask[i]),
            .data_i           (push_out),
            .ready_i          (ready_i[i]),
            .valid_o          (valid_o[i]),
            .data_o           (rsp_o[i]),
            .usage_o          (usage_o[i]),
            .clr_error_i      (clr_error_i[i]),
            .error_overflow_o (error_overflow_o[i]),
            .drop_cnt_o       (drop_cnt_o[i])
        );
    end

endmodule

// File: tb/tb_fractal_sync_tx_nch.sv
// Bench for fractal_sync_tx_nch: 4-channel registered-input instance with a scoreboard monitor,
// plus a 2-channel combinational-input instance for same-cycle push checks.
module tb_fractal_sync_tx_nch;
    import fractal_sync_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 4-channel, registered input
    fsync_rsp_in_t      rsp_i;
    logic               valid_o [4];
    fsync_rsp_out_4ch_t rsp_o   [4];
    logic               ready_i [4];
    logic [1:0]         usage_o [4];
    logic               err_o   [4];
    logic [7:0]         cnt_o   [4];
    logic               clr_i   [4];

    // 2-channel, combinational input
    fsync_rsp_in_t      rsp_c;
    logic               valid_c [2];
    fsync_rsp_out_t     rsp_c_o [2];
    logic               ready_c [2];
    logic [1:0]         usage_c [2];
    logic               err_c   [2];
    logic [7:0]         cnt_c   [2];
    logic               clr_c   [2];

    fractal_sync_tx_nch #(
        .fsync_rsp_in_t  (fsync_rsp_in_t),
        .fsync_rsp_out_t (fsync_rsp_out_4ch_t),
        .NUM_CH          (4),
        .FIFO_DEPTH      (2),
        .COMB_IN         (1'b0)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .rsp_i            (rsp_i),
        .valid_o          (valid_o),
        .rsp_o            (rsp_o),
        .ready_i          (ready_i),
        .usage_o          (usage_o),
        .error_overflow_o (err_o),
        .drop_cnt_o       (cnt_o),
        .clr_error_i      (clr_i)
    );

    fractal_sync_tx_nch #(
        .fsync_rsp_in_t  (fsync_rsp_in_t),
        .fsync_rsp_out_t (fsync_rsp_out_t),
        .NUM_CH          (2),
        .FIFO_DEPTH      (2),
        .COMB_IN         (1'b1)
    ) dut_c (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .rsp_i            (rsp_c),
        .valid_o          (valid_c),
        .rsp_o            (rsp_c_o),
        .ready_i          (ready_c),
        .usage_o          (usage_c),
        .error_overflow_o (err_c),
        .drop_cnt_o       (cnt_c),
        .clr_error_i      (clr_c)
    );

    fsync_rsp_out_4ch_t exp_q [4][$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one wake; expected outputs are enqueued for channels where it will be stored
    task automatic send(input logic [7:0] dst, input logic err, input bit keep);
        fsync_rsp_out_4ch_t e;
        rsp_i.wake  = 1'b1;
        rsp_i.dst   = dst;
        rsp_i.error = err;
        e.wake  = 1'b1;
        e.dst   = dst[7:4];
        e.error = err;
        if (keep) begin
            for (int c = 0; c < 4; c++) begin
                if (dst[c]) exp_q[c].push_back(e);
            end
        end
    endtask

    task automatic idle();
        rsp_i = '0;
    endtask

    // Monitor: a handshake seen at the falling edge completes at the next rising edge
    initial begin : monitor
        fsync_rsp_out_4ch_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (rst_n && valid_o[i] && ready_i[i]) begin
                    n_cmp++;
                    if (exp_q[i].size() == 0) begin
                        n_fail++;
                        $display("FAIL mon_ch%0d: got %0h, expected no output", i, rsp_o[i]);
                    end else begin
                        e = exp_q[i].pop_front();
                        if (rsp_o[i] !== e) begin
                            n_fail++;
                            $display("FAIL mon_ch%0d: got %0h, expected %0h", i, rsp_o[i], e);
                        end
                    end
                end
            end
        end
    end

    initial begin : stim
        fsync_rsp_out_t ec;
        rsp_i = '0;
        rsp_c = '0;
        for (int i = 0; i < 4; i++) begin
            ready_i[i] = 1'b0;
            clr_i[i]   = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            ready_c[i] = 1'b0;
            clr_c[i]   = 1'b0;
        end

        // Reset state, with a live wake on the combinational instance
        rsp_c = '{wake: 1'b1, dst: 8'h01, error: 1'b0};
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_valid%0d", i), 32'(valid_o[i]), 32'd0);
            chk($sformatf("rst_usage%0d", i), 32'(usage_o[i]), 32'd0);
            chk($sformatf("rst_err%0d", i),   32'(err_o[i]),   32'd0);
            chk($sformatf("rst_cnt%0d", i),   32'(cnt_o[i]),   32'd0);
            chk($sformatf("rst_rsp%0d", i),   32'(rsp_o[i]),   32'd0);
        end
        chk("rst_valid_c0", 32'(valid_c[0]), 32'd0);
        chk("rst_rsp_c0",   32'(rsp_c_o[0]), 32'd0);
        rsp_c = '0;
        rst_n = 1'b1;
        step();

        // Multicast to channels 0 and 2, dst stripped by 4
        send(8'hA5, 1'b0, 1'b1);
        step();
        idle();
        chk("mc_valid0", 32'(valid_o[0]), 32'd1);
        chk("mc_valid1", 32'(valid_o[1]), 32'd0);
        chk("mc_valid2", 32'(valid_o[2]), 32'd1);
        chk("mc_valid3", 32'(valid_o[3]), 32'd0);
        chk("mc_dst0",   32'(rsp_o[0].dst), 32'hA);
        chk("mc_dst2",   32'(rsp_o[2].dst), 32'hA);
        step();
        chk("mc_usage0", 32'(usage_o[0]), 32'd1);
        chk("mc_usage1", 32'(usage_o[1]), 32'd0);
        chk("mc_usage2", 32'(usage_o[2]), 32'd1);
        ready_i[0] = 1'b1;
        ready_i[2] = 1'b1;
        step();
        ready_i[0] = 1'b0;
        ready_i[2] = 1'b0;
        chk("mc_drained0", 32'(usage_o[0]), 32'd0);
        chk("mc_drained_v0", 32'(valid_o[0]), 32'd0);

        // Three pushes to channel 1 with ready low: third is dropped
        send(8'h12, 1'b0, 1'b1);
        step();
        send(8'h22, 1'b1, 1'b1);
        step();
        send(8'h32, 1'b0, 1'b0);
        step();
        idle();
        chk("ovf_not_early", 32'(err_o[1]), 32'd0);
        step();
        step();
        chk("ovf_usage1", 32'(usage_o[1]), 32'd2);
        chk("ovf_err1",   32'(err_o[1]),   32'd1);
        chk("ovf_cnt1",   32'(cnt_o[1]),   32'd1);
        clr_i[1] = 1'b1;
        step();
        clr_i[1] = 1'b0;
        chk("clr_err1", 32'(err_o[1]), 32'd0);
        chk("clr_cnt1", 32'(cnt_o[1]), 32'd0);

        // Push into full channel 1 while it pops
        send(8'h42, 1'b0, 1'b1);
        step();
        idle();
        ready_i[1] = 1'b1;
        step();
        ready_i[1] = 1'b0;
        chk("pp_usage1", 32'(usage_o[1]), 32'd2);
        chk("pp_err1",   32'(err_o[1]),   32'd0);
        chk("pp_cnt1",   32'(cnt_o[1]),   32'd0);
        ready_i[1] = 1'b1;
        step();
        step();
        ready_i[1] = 1'b0;
        chk("pp_drained1", 32'(usage_o[1]), 32'd0);

        // 302 pushes to channel 3: two stored, 300 dropped
        for (int k = 0; k < 302; k++) begin
            send({4'(k), 4'b1000}, 1'b0, k < 2);
            step();
        end
        idle();
        step();
        step();
        chk("sat_cnt3",   32'(cnt_o[3]),   32'd255);
        chk("sat_err3",   32'(err_o[3]),   32'd1);
        chk("sat_usage3", 32'(usage_o[3]), 32'd2);
        clr_i[3] = 1'b1;
        step();
        clr_i[3] = 1'b0;
        chk("sat_clr_cnt3", 32'(cnt_o[3]), 32'd0);
        chk("sat_clr_err3", 32'(err_o[3]), 32'd0);
        send(8'hF8, 1'b0, 1'b0);
        step();
        idle();
        clr_i[3] = 1'b1;
        step();
        clr_i[3] = 1'b0;
        chk("clr_vs_drop_err3", 32'(err_o[3]), 32'd1);
        chk("clr_vs_drop_cnt3", 32'(cnt_o[3]), 32'd1);
        ready_i[3] = 1'b1;
        step();
        step();
        ready_i[3] = 1'b0;
        chk("sat_drained3", 32'(usage_o[3]), 32'd0);

        // Reset with two entries in channel 0 and a registered push to channel 2 pending
        send(8'h51, 1'b0, 1'b1);
        step();
        send(8'h61, 1'b0, 1'b1);
        step();
        send(8'h74, 1'b0, 1'b1);
        step();
        idle();
        chk("pre_rst_usage0", 32'(usage_o[0]), 32'd2);
        chk("pre_rst_pend2",  32'(valid_o[2]), 32'd1);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_q[i].delete();
            chk($sformatf("mid_rst_valid%0d", i), 32'(valid_o[i]), 32'd0);
            chk($sformatf("mid_rst_usage%0d", i), 32'(usage_o[i]), 32'd0);
            chk($sformatf("mid_rst_rsp%0d", i),   32'(rsp_o[i]),   32'd0);
        end
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rel_valid%0d", i), 32'(valid_o[i]), 32'd0);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rel1_valid%0d", i), 32'(valid_o[i]), 32'd0);
            chk($sformatf("rel1_usage%0d", i), 32'(usage_o[i]), 32'd0);
        end

        // Combinational input: same-cycle valid, then wake=0 ignored
        rsp_c = '{wake: 1'b1, dst: 8'hC1, error: 1'b1};
        #1;
        ec.wake  = 1'b1;
        ec.dst   = 6'h30;
        ec.error = 1'b1;
        chk("comb_valid0", 32'(valid_c[0]), 32'd1);
        chk("comb_valid1", 32'(valid_c[1]), 32'd0);
        chk("comb_rsp0",   32'(rsp_c_o[0]), 32'(ec));
        step();
        rsp_c = '{wake: 1'b0, dst: 8'h03, error: 1'b0};
        #1;
        chk("comb_usage0", 32'(usage_c[0]), 32'd1);
        chk("nowake_valid1", 32'(valid_c[1]), 32'd0);
        step();
        chk("nowake_usage0", 32'(usage_c[0]), 32'd1);
        chk("nowake_usage1", 32'(usage_c[1]), 32'd0);
        rsp_c = '0;

        for (int i = 0; i < 4; i++) begin
            chk($sformatf("sb_empty%0d", i), 32'(exp_q[i].size()), 32'd0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fractal_sync_tx_nch.md
FRACTAL_SYNC_TX_NCH -- requirements
Module: fractal_sync_tx_nch

Interface
REQ-001 SHALL have parameter fsync_rsp_in_t, default logic, meaning input response struct with fields wake, dst, error.
REQ-002 SHALL have parameter fsync_rsp_out_t, default logic, meaning output response struct with fields wake, dst, error.
REQ-003 SHALL have parameter NUM_CH, default 2, meaning number of output channels; power of two and >= 2.
REQ-004 SHALL have parameter FIFO_DEPTH, default 2, meaning entries per channel FIFO; >= 1.
REQ-005 SHALL have parameter COMB_IN, default 0, meaning 1 = combinational input path, 0 = registered input.
REQ-006 SHALL have port clk_i  input  1  single clock, rising edge.
REQ-007 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port rsp_i  input  fsync_rsp_in_t  incoming synchronization response.
REQ-009 SHALL have port valid_o[NUM_CH]  output  1 each  channel holds a response.
REQ-010 SHALL have port rsp_o[NUM_CH]  output  fsync_rsp_out_t each  head response of channel.
REQ-011 SHALL have port ready_i[NUM_CH]  input  1 each  consumer accepts head response.
REQ-012 SHALL have port usage_o[NUM_CH]  output  $clog2(FIFO_DEPTH+1) each  current occupancy.
REQ-013 SHALL have port error_overflow_o[NUM_CH]  output  1 each  sticky overflow flag.
REQ-014 SHALL have port drop_cnt_o[NUM_CH]  output  8 each  saturating count of dropped responses.
REQ-015 SHALL have port clr_error_i[NUM_CH]  input  1 each  clears the flag and the counter of the channel.

Function
REQ-016 SHALL push a response into channel i when rsp_i.wake=1 and rsp_i.dst[i]=1; several dst bits set SHALL multicast the response to all selected channels in the same cycle.
REQ-017 SHALL ignore rsp_i when wake=0, and SHALL ignore wake=1 with dst[NUM_CH-1:0]=0 without raising an error.
REQ-018 SHALL form the output response as wake and error copied unchanged and dst = input dst shifted right logically by NUM_CH.
REQ-019 SHALL, for COMB_IN=1, perform the push in the same cycle as rsp_i; for COMB_IN=0, it SHALL register rsp_i (sampled only when wake=1) and the push flags, and perform the push one cycle later.
REQ-020 SHALL be fall-through: a push into an empty channel SHALL raise valid_o and drive rsp_o in the same cycle as the push.
REQ-021 SHALL pop channel i when valid_o[i] & ready_i[i] at a rising edge; rsp_o[i] SHALL hold stable while valid_o[i]=1 and ready_i[i]=0.
REQ-022 SHALL accept a push into a full channel when that channel pops in the same cycle; usage SHALL then stay at FIFO_DEPTH.
REQ-023 SHALL, on a push into a full channel without a simultaneous pop, drop the response, set error_overflow_o[i] from the next cycle, and increment drop_cnt_o[i], saturating at 255.
REQ-024 SHALL give overflow precedence over clr_error_i when both occur in the same cycle: the flag stays 1 and the counter becomes 1.
REQ-025 SHALL leave each FIFO's read and write pointers wrapping modulo FIFO_DEPTH, valid for non-power-of-two depths.
REQ-026 SHALL keep usage_o consistent: +1 on push only, -1 on pop only, unchanged on push+pop.

Reset
REQ-027 SHALL, while rst_ni=0, drive valid_o=0, usage_o=0, error_overflow_o=0, drop_cnt_o=0 and rsp_o='0, and clear all sampling registers.
REQ-028 SHALL discard all stored and in-flight (registered) responses on reset asserted mid-operation, with no push occurring in the first cycle after release.

Structure
REQ-029 SHALL take the response struct typedefs and the drop counter width constant (8) from fractal_sync_pkg.
REQ-030 SHALL instantiate one sub-module per channel, fractal_sync_tx_ch_fifo: a fall-through FIFO with push-while-full-on-pop support, usage output, and overflow/drop-counter logic.
REQ-031 SHALL include elaboration assertions on NUM_CH being a power of two and >= 2, FIFO_DEPTH >= 1, and out dst width = in dst width - NUM_CH.

Verification
REQ-032 SHALL cover NUM_CH=4, COMB_IN=0, a single wake with dst=0b1010_0101 -> channels 0 and 2 valid one cycle later with rsp_o.dst=0b1010, and usage=1.
REQ-033 SHALL cover FIFO_DEPTH=2 with ready=0 and 3 pushes to channel 1 -> usage_o[1]=2, error_overflow_o[1]=1, drop_cnt_o[1]=1, and the first two responses are preserved in order.
REQ-034 SHALL cover a full channel receiving a push with ready_i=1 in the same cycle -> no error, usage stays 2, and the new response is popped third.
REQ-035 SHALL cover 300 drops followed by clr_error_i -> counter held at 255 then 0 and flag 0; clear coincident with a drop -> flag 1 and counter 1.
REQ-036 SHALL cover COMB_IN=1 with wake and dst=0b01 -> valid_o[0] is 1 in the same cycle; wake=0 with dst=0b11 -> no push.
REQ-037 SHALL cover rst_ni pulsed low with 2 stored entries and one registered push pending -> all outputs zero, and valid_o=0 after release.
